// File: rtl/conv_window_gen.sv
// Streaming 3x3 window generator: turns a raster pixel stream into packed
// valid-mode convolution windows using two line buffers and a 3x3 shift register.
module conv_window_gen #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int PIX_W = 8
) (
  input  logic               clk,
  input  logic               rstn_,
  input  logic               start,
  input  logic [PIX_W-1:0]   pix_in,
  input  logic               pix_valid,
  output logic               pix_ready,
  output logic [9*PIX_W-1:0] win_data,
  output logic               win_valid,
  output logic               busy,
  output logic               frame_done
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [XW-1:0]      x;
  logic [YW-1:0]      y;
  logic [PIX_W-1:0]   lb0 [IMG_W];
  logic [PIX_W-1:0]   lb1 [IMG_W];
  logic [9*PIX_W-1:0] win;
  logic [9*PIX_W-1:0] win_next;
  logic               accept;
  logic               emit;

  assign pix_ready = (state == RUN);
  assign busy      = (state != IDLE);
  assign accept    = pix_valid && pix_ready;
  assign emit      = accept && (x >= XW'(2)) && (y >= YW'(2));

  // Each row of the window shifts left; the new right column is rows y-2, y-1, y.
  always_comb begin
    win_next = win;
    for (int r = 0; r < 3; r++) begin
      win_next[(3*r)*PIX_W +: PIX_W]   = win[(3*r+1)*PIX_W +: PIX_W];
      win_next[(3*r+1)*PIX_W +: PIX_W] = win[(3*r+2)*PIX_W +: PIX_W];
    end
    win_next[2*PIX_W +: PIX_W] = lb1[x];
    win_next[5*PIX_W +: PIX_W] = lb0[x];
    win_next[8*PIX_W +: PIX_W] = pix_in;
  end

  // Line buffers hold no reset: every column is rewritten before a window can use it.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[x] <= lb0[x];
      lb0[x] <= pix_in;
    end
  end

  always_ff @(posedge clk or negedge rstn_) begin
    if (!rstn_) begin
      state      <= IDLE;
      x          <= '0;
      y          <= '0;
      win        <= '0;
      win_data   <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      win_valid  <= emit;
      frame_done <= 1'b0;
      if (accept) win <= win_next;
      if (emit) win_data <= win_next;
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            x     <= '0;
            y     <= '0;
          end
        end
        RUN: begin
          if (accept) begin
            if (x == X_LAST) begin
              x <= '0;
              if (y == Y_LAST) begin
                y          <= '0;
                state      <= DONE;
                frame_done <= 1'b1;
              end else begin
                y <= y + YW'(1);
              end
            end else begin
              x <= x + XW'(1);
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
- Producer side of the 3x3 convolution engine interface: accepts a raster-order pixel stream and emits one packed 3x3 window per valid output position (valid-mode convolution, no padding).
- Holds two line buffers of IMG_W pixels each, plus a 3x3 window shift register, counters and a frame FSM.
- `win_data` / `win_valid` connect directly to the engine's pixel bus (`nums_to_multiply`) and enable; weights are supplied separately.

Parameters:
- IMG_W, 8: image width in pixels; must be >= 3.
- IMG_H, 8: image height in pixels; must be >= 3.
- PIX_W, 8: bits per pixel; window width is 9*PIX_W.

Ports:
- clk  in  1  clock.
- rstn_  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a frame; honoured only in IDLE.
- pix_in  in  PIX_W  pixel, raster order (row 0 col 0 first).
- pix_valid  in  1  pix_in is valid.
- pix_ready  out  1  block accepts a pixel this cycle.
- win_data  out  9*PIX_W  packed window; lane i = win_data[i*PIX_W +: PIX_W].
- win_valid  out  1  win_data holds a new window; one-cycle pulse per window.
- busy  out  1  FSM is not in IDLE.
- frame_done  out  1  one-cycle pulse at end of frame.

Behaviour:
- Reset is asynchronous and active-low (`rstn_`) on the single clock `clk`.
  - Reset values: state = IDLE, column/row counters = 0, win_data = 0, win_valid = 0, frame_done = 0, window registers = 0.
  - Line-buffer RAM contents are not reset; the fill rules below guarantee stale data never reaches an emitted window.
- FSM:
  - IDLE: start=1 -> RUN, counters cleared.
  - RUN: pix_ready=1. When the last pixel is accepted (x=IMG_W-1, y=IMG_H-1) -> DONE.
  - DONE: one cycle, then -> IDLE.
  - frame_done=1 exactly while in DONE.
  - busy=1 in RUN and DONE.
- pix_ready = (state==RUN); it is low in IDLE and DONE. A pixel is accepted when pix_valid & pix_ready.
- Any pix_valid in IDLE or DONE is ignored, and no counter moves.
- start asserted in RUN or DONE is ignored.
- On an accepted pixel at column x, row y:
  - Read lb1[x] (row y-2) and lb0[x] (row y-1).
  - Shift the window one column left; the new right column is {lb1[x], lb0[x], pix_in} (top, middle, bottom).
  - Write lb1[x] <= lb0[x] and lb0[x] <= pix_in.
  - Increment x, wrapping at IMG_W-1 to 0 and incrementing y.
- Window packing:
  - lane = 3*r + c.
  - r=0 is the top row (y-2), r=2 is the current row.
  - c=0 is the leftmost column (x-2).
  - Lane 8 is the just-accepted pixel.
- Output timing:
  - win_valid goes high the cycle after an accepted pixel with x>=2 and y>=2; latency is 1 cycle, and win_data is registered in that same edge.
  - Otherwise win_valid=0. win_data holds its last value when win_valid=0.
  - Windows per frame: (IMG_W-2)*(IMG_H-2).
- The window shift register is not cleared at row wrap. Columns x=0,1 of a new row produce no window, so left-edge wrap data is flushed before the next emission.
- Gaps in pix_valid stall the block with no state change; output windows are identical to the gap-free case.
- The last window's win_valid and frame_done assert in the same cycle.
- No output backpressure: the downstream engine accepts every win_valid.
- Reset asserted mid-frame: immediate return to IDLE with all outputs at reset values; the next frame requires a new start.
- Counter widths are $clog2(IMG_W) and $clog2(IMG_H); there are no arithmetic overflow cases.

Test Plan:
- IMG_W=IMG_H=4, start, then 16 back-to-back pixels with value y*4+x+1 -> exactly 4 win_valid pulses.
  - First pulse, the cycle after pixel 11 is accepted: lanes 0..8 = 1,2,3,5,6,7,9,10,11.
  - Second: 2,3,4,6,7,8,10,11,12.
  - Third: 5,6,7,9,10,11,13,14,15.
  - Fourth: 6,7,8,10,11,12,14,15,16, with frame_done=1 in the same cycle.
- Same frame with pix_valid deasserted on random cycles (about 50%) -> identical 4 windows in order; pix_ready stays 1 throughout RUN.
- pix_valid=1 in IDLE with no start -> pix_ready=0, no win_valid, busy=0. Then start=1 pulsed during RUN -> ignored, frame completes with 4 windows.
- Reset asserted after pixel 9 of the 4x4 frame -> win_valid, frame_done, busy and pix_ready go to 0 asynchronously. Then a new start plus a full frame with values 101..116 -> first window = 101,102,103,105,106,107,109,110,111 (no stale data).
- Two frames back-to-back with a different image, start pulsed the cycle after frame_done -> second frame's windows contain only second-frame pixels; 4 windows each frame.
- IMG_W=5, IMG_H=3, pixels 1..15 -> 3 windows; first window = 1,2,3,6,7,8,11,12,13; last window = 3,4,5,8,9,10,13,14,15.
